// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing helpers shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_e;
  function automatic int clk_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int cnt_width(input int cpb);
    return $clog2(cpb) + 1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous circular-buffer FIFO with registered occupancy count.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         din,
  input  logic                     pop,
  output logic [Width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(Depth);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, start bit + LSB-first payload + stop bit(s), idle-high line.
module uart_tx import uart_pkg::*; #(
  parameter int Param_BaurdRate   = 9600,
  parameter int Param_ClkFreq     = 1000000,
  parameter int Param_PayloadBits = 8,
  parameter int Param_StopBits    = 1,
  parameter int Param_FifoDepth   = 4
) (
  input  logic                               IO_Clk_I,
  input  logic                               IO_Rst_I,
  input  logic [Param_PayloadBits-1:0]       IO_TxData_I,
  input  logic                               IO_TxValid_I,
  output logic                               IO_TxReady_O,
  output logic                               IO_Tx_O,
  output logic                               IO_TxBusy_O,
  output logic [$clog2(Param_FifoDepth):0]   IO_FifoCount_O
);
  localparam int CPB = clk_per_bit(Param_ClkFreq, Param_BaurdRate);
  localparam int CW = cnt_width(CPB);
  localparam int BW = 4;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [Param_PayloadBits-1:0] shift_q, shift_d, fifo_dout;
  logic tx_q, tx_d, push, pop, full, empty, bit_end, last_data, last_stop;
  assign bit_end = cnt_q == CW'(CPB - 1);
  assign last_data = bit_q == BW'(Param_PayloadBits - 1);
  assign last_stop = bit_q == BW'(Param_StopBits - 1);
  assign push = IO_TxValid_I && !full;
  // popping on the final stop cycle chains frames with no idle gap
  assign pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end && last_stop));
  uart_tx_fifo #(.Width(Param_PayloadBits), .Depth(Param_FifoDepth)) u_fifo (
    .clk   (IO_Clk_I),
    .rst_n (IO_Rst_I),
    .push  (push),
    .din   (IO_TxData_I),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (IO_FifoCount_O)
  );
  always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
    if (!IO_Rst_I) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = pop ? START : IDLE;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && last_data) ? STOP : DATA;
      STOP:    state_d = !(bit_end && last_stop) ? STOP : pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // line level is computed from next-state values so the register leads the phase it encodes
  always_comb begin
    cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    bit_d = (state_d != state_q) ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
    shift_d = pop ? fifo_dout : (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
  end
  assign IO_Tx_O = tx_q;
  assign IO_TxReady_O = !full;
  assign IO_TxBusy_O = (state_q != IDLE) || !empty;
endmodule
